instr_encoder: RTL

//  Inverse of the decode-side immediate sign extension. Packs opcode/rd/rs/immediate

---
 rtl/instr_encoder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Packs opcode/rd/rs/immediate field bundles into 8-bit instruction words
//   and streams them into instruction memory. The inverse of the decode-side
//   immediate sign extension: signed immediates are range-checked down to
//   their encoded width before packing.
//
//   Encodings:
//     li/addi : {op, rd, imm[2:0]}                legal imm -4..+3
//     reg-reg : {2'b10, rd, rs}                   imm ignored
//     jump    : {2'b11, imm[4], 2'b00, imm[2:0]}  legal imm -8..+7
//
// Configuration macro:
//   ENC_IMM_SAT_EN  defined   -> an out-of-range imm is clamped to the
//                                nearest legal value and the word is written
//                                (err_range is still raised as a warning).
//                   undefined -> an out-of-range bundle is consumed, flagged
//                                and skipped (no write, address unchanged).
//
// Parameters:
//   ADDR_W  imem address width (program depth = 2**ADDR_W words)
//   BASE    first imem address written after start
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   start       in   pulse in IDLE: clear counter/error, begin a load
//   in_valid    in   field bundle valid
//   in_ready    out  bundle can be accepted
//   in_op       in   00 li, 01 addi, 10 reg-reg, 11 jump
//   in_rd       in   destination register
//   in_rs       in   source register (reg-reg only)
//   in_imm      in   signed immediate / jump offset
//   in_last     in   final bundle of the program
//   imem_we     out  instruction-memory write strobe
//   imem_addr   out  write address
//   imem_wdata  out  encoded instruction
//   done        out  one-cycle pulse when the load completes
//   err_range   out  sticky out-of-range immediate flag
//   word_cnt    out  words written since start
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W = 3,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              done,
  output logic              err_range,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

  // DRAIN covers the cycle in which the final word is on the write port;
  // input is refused there so done lands one cycle after the last write.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_err;
  logic [ADDR_W:0]   r_cnt;

  logic              w_accept;
  logic              w_is_rr;
  logic              w_is_jump;
  logic              w_short_ok;
  logic              w_jump_ok;
  logic              w_in_range;
  logic [2:0]        w_imm_lo;
  logic              w_imm_j4;
  logic              w_do_write;
  logic              w_fills;
  logic              w_ends;
  logic [7:0]        w_word;

  assign in_ready = (r_state == S_RUN);
  assign w_accept = in_valid & in_ready;

  assign w_is_rr   = (in_op == 2'b10);
  assign w_is_jump = (in_op == 2'b11);

  // An immediate fits when every bit above the encoded sign bit is a copy
  // of it, i.e. the upper slice is all ones or all zeros.
  assign w_short_ok = (&in_imm[7:2]) | ~(|in_imm[7:2]);
  assign w_jump_ok  = (&in_imm[7:3]) | ~(|in_imm[7:3]);
  assign w_in_range = w_is_rr | (w_is_jump ? w_jump_ok : w_short_ok);

`ifdef ENC_IMM_SAT_EN
  // Clamp toward the sign of the original value: negative goes to the most
  // negative encodable value, positive to the most positive.
  always_comb begin
    w_imm_lo = in_imm[2:0];
    w_imm_j4 = in_imm[4];
    if (!w_in_range) begin
      if (in_imm[7]) begin
        w_imm_lo = w_is_jump ? 3'b000 : 3'b100;
        w_imm_j4 = 1'b1;
      end else begin
        w_imm_lo = w_is_jump ? 3'b111 : 3'b011;
        w_imm_j4 = 1'b0;
      end
    end
  end
  assign w_do_write = w_accept;
`else
  assign w_imm_lo   = in_imm[2:0];
  assign w_imm_j4   = in_imm[4];
  assign w_do_write = w_accept & w_in_range;
`endif

  // Pack the accepted bundle into its instruction word.
  always_comb begin
    w_word = 8'h00;
    case (in_op)
      2'b10:   w_word = {2'b10, in_rd, in_rs};
      2'b11:   w_word = {2'b11, w_imm_j4, 2'b00, w_imm_lo};
      default: w_word = {in_op, in_rd, w_imm_lo};
    endcase
  end

  // The load ends on an explicit last bundle (written or not) or when the
  // write that fills the final address is issued.
  assign w_fills = w_do_write && (r_cnt == LAST_CNT);
  assign w_ends  = w_accept && (in_last || w_fills);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the done pulse.
  always_comb begin
    w_next_state = r_state;
    done         = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_ends) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered write port, word counter and sticky range flag. The address
  // is taken from the counter before it increments, so it wraps naturally
  // within ADDR_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= BASE_A;
      r_wdata <= 8'h00;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_do_write;
      if (w_do_write) begin
        r_addr  <= BASE_A + r_cnt[ADDR_W-1:0];
        r_wdata <= w_word;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (r_state == S_IDLE && start) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_accept && !w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign err_range  = r_err;
  assign word_cnt   = r_cnt;

endmodule
